// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_LOADUSE = 6'b000111;
  localparam logic [5:0] STALL_EX      = 6'b001111;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard/stall signal bundle between pipeline and controller
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              ex_is_load_i;
  logic [4:0]        ex_wd_i;
  logic              id_reg1_read_i;
  logic [4:0]        id_reg1_addr_i;
  logic              id_reg2_read_i;
  logic [4:0]        id_reg2_addr_i;
  logic              ex_multi_start_i;
  logic [CNT_W-1:0]  ex_multi_cycles_i;
  logic              flush_req_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic              ex_done_o;
  logic              busy_o;
  logic [PERF_W-1:0] stall_cnt_o;

  modport master (
    output ex_is_load_i, ex_wd_i, id_reg1_read_i, id_reg1_addr_i,
           id_reg2_read_i, id_reg2_addr_i, ex_multi_start_i,
           ex_multi_cycles_i, flush_req_i,
    input  stall_o, flush_o, ex_done_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  ex_is_load_i, ex_wd_i, id_reg1_read_i, id_reg1_addr_i,
           id_reg2_read_i, id_reg2_addr_i, ex_multi_start_i,
           ex_multi_cycles_i, flush_req_i,
    output stall_o, flush_o, ex_done_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - W-bit saturating incrementer with enable
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use detection, multi-cycle EX sequencing and flush control
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W      = 6,
  parameter int MAX_CYCLES = 34,
  parameter int PERF_W     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_clamped;
  logic             load_use;
  logic [5:0]       stall_d;
  logic             flush_d;
  logic             done_d;
  logic [5:0]       stall_out;

  always_comb begin
    load_use = hz.ex_is_load_i && (hz.ex_wd_i != 5'd0) &&
               ((hz.id_reg1_read_i && (hz.id_reg1_addr_i == hz.ex_wd_i)) ||
                (hz.id_reg2_read_i && (hz.id_reg2_addr_i == hz.ex_wd_i)));

    n_clamped = (hz.ex_multi_cycles_i > CNT_W'(MAX_CYCLES)) ? CNT_W'(MAX_CYCLES)
                                                           : hz.ex_multi_cycles_i;
  end

  // An op of N cycles stalls for N-1 cycles counting the start cycle; done rides the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = STALL_NONE;
    flush_d = 1'b0;
    done_d  = 1'b0;

    if (hz.flush_req_i) begin
      flush_d = 1'b1;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_MULTI) begin
      stall_d = STALL_EX;
      if (cnt_q == '0) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      if (load_use) begin
        stall_d = STALL_LOADUSE;
      end
      if (hz.ex_multi_start_i) begin
        if (n_clamped <= CNT_W'(1)) begin
          done_d = 1'b1;
        end else begin
          stall_d = STALL_EX;
          if (n_clamped == CNT_W'(2)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_MULTI;
            cnt_d   = n_clamped - CNT_W'(3);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are same-cycle decisions, so they are gated directly by reset.
  assign stall_out    = rst_n ? stall_d : STALL_NONE;
  assign hz.stall_o   = stall_out;
  assign hz.flush_o   = rst_n & flush_d;
  assign hz.ex_done_o = rst_n & done_d;
  assign hz.busy_o    = rst_n & (state_q == ST_MULTI);

  sat_counter #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (|stall_out),
    .cnt_o (hz.stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(6), .PERF_W(32)) hz ();
  pipe_hazard_ctrl_if #(.CNT_W(6), .PERF_W(3))  hz_s ();

  assign hz_s.ex_is_load_i      = hz.ex_is_load_i;
  assign hz_s.ex_wd_i           = hz.ex_wd_i;
  assign hz_s.id_reg1_read_i    = hz.id_reg1_read_i;
  assign hz_s.id_reg1_addr_i    = hz.id_reg1_addr_i;
  assign hz_s.id_reg2_read_i    = hz.id_reg2_read_i;
  assign hz_s.id_reg2_addr_i    = hz.id_reg2_addr_i;
  assign hz_s.ex_multi_start_i  = hz.ex_multi_start_i;
  assign hz_s.ex_multi_cycles_i = hz.ex_multi_cycles_i;
  assign hz_s.flush_req_i       = hz.flush_req_i;

  pipe_hazard_ctrl #(.CNT_W(6), .MAX_CYCLES(34), .PERF_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  pipe_hazard_ctrl #(.CNT_W(6), .MAX_CYCLES(34), .PERF_W(3)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_s)
  );

  int    checks = 0;
  int    errors = 0;
  int    rem    = 0;
  longint scnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit ld, input int wd, input bit r1, input int a1,
                        input bit r2, input int a2, input bit st, input int cyc,
                        input bit fl);
    hz.ex_is_load_i      = ld;
    hz.ex_wd_i           = 5'(wd);
    hz.id_reg1_read_i    = r1;
    hz.id_reg1_addr_i    = 5'(a1);
    hz.id_reg2_read_i    = r2;
    hz.id_reg2_addr_i    = 5'(a2);
    hz.ex_multi_start_i  = st;
    hz.ex_multi_cycles_i = 6'(cyc);
    hz.flush_req_i       = fl;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Model: an N-cycle op stalls N-1 cycles starting with the request cycle, done on the last.
  task automatic run_cycle(input string tag);
    logic [5:0] es;
    bit ef, ed, eb, lu;
    int n, rn;
    @(negedge clk);
    n  = (int'(hz.ex_multi_cycles_i) > 34) ? 34 : int'(hz.ex_multi_cycles_i);
    lu = hz.ex_is_load_i && hz.ex_wd_i != 0 &&
         ((hz.id_reg1_read_i && hz.id_reg1_addr_i == hz.ex_wd_i) ||
          (hz.id_reg2_read_i && hz.id_reg2_addr_i == hz.ex_wd_i));
    es = 6'b000000; ef = 0; ed = 0; eb = (rem > 0); rn = rem;
    if (hz.flush_req_i) begin
      ef = 1; rn = 0;
    end else if (rem > 0) begin
      es = 6'b001111; ed = (rem == 1); rn = rem - 1;
    end else begin
      if (lu) es = 6'b000111;
      if (hz.ex_multi_start_i) begin
        if (n >= 2) begin
          es = 6'b001111; rn = n - 2; ed = (n == 2);
        end else begin
          ed = 1;
        end
      end
    end
    chk({tag, ".stall"}, 32'(hz.stall_o), 32'(es));
    chk({tag, ".flush"}, 32'(hz.flush_o), 32'(ef));
    chk({tag, ".done"},  32'(hz.ex_done_o), 32'(ed));
    chk({tag, ".busy"},  32'(hz.busy_o), 32'(eb));
    chk({tag, ".cnt"},   hz.stall_cnt_o, 32'(scnt));
    chk({tag, ".cnt3"},  32'(hz_s.stall_cnt_o), 32'((scnt > 7) ? 7 : scnt));
    chk({tag, ".stall3"}, 32'(hz_s.stall_o), 32'(es));
    @(posedge clk);
    rem = rn;
    if (es != 0) scnt++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1, 5, 1, 5, 0, 0, 1, 10, 1);
    #12;
    chk("rst.stall", 32'(hz.stall_o), 32'd0);
    chk("rst.flush", 32'(hz.flush_o), 32'd0);
    chk("rst.done",  32'(hz.ex_done_o), 32'd0);
    chk("rst.busy",  32'(hz.busy_o), 32'd0);
    chk("rst.cnt",   hz.stall_cnt_o, 32'd0);
    idle_in();
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // DIV at maximum latency
    set_in(0, 0, 0, 0, 0, 0, 1, 34, 0);
    run_cycle("div_start");
    idle_in();
    for (int i = 0; i < 34; i++) run_cycle("div");
    chk("div.total", hz.stall_cnt_o, 32'd33);
    chk("div.sat3", 32'(hz_s.stall_cnt_o), 32'd7);

    // load-use variants
    set_in(1, 5, 1, 5, 0, 0, 0, 0, 0); run_cycle("lu_r1");
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0); run_cycle("lu_r0");
    set_in(1, 9, 0, 9, 1, 9, 0, 0, 0); run_cycle("lu_r2");
    set_in(0, 9, 1, 9, 1, 9, 0, 0, 0); run_cycle("lu_noload");
    set_in(1, 9, 0, 9, 0, 9, 0, 0, 0); run_cycle("lu_noread");

    // short and clamped ops
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);  run_cycle("short1");
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);  run_cycle("short0");
    set_in(0, 0, 0, 0, 0, 0, 1, 2, 0);  run_cycle("short2");
    set_in(0, 0, 0, 0, 0, 0, 1, 63, 0); run_cycle("clamp_start");
    set_in(0, 0, 0, 0, 0, 0, 1, 5, 0);
    for (int i = 0; i < 34; i++) run_cycle("clamp");

    // flush aborts a running op
    set_in(0, 0, 0, 0, 0, 0, 1, 10, 0); run_cycle("fl_start");
    idle_in();
    for (int i = 0; i < 3; i++) run_cycle("fl_run");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle("fl_hit");
    idle_in();
    for (int i = 0; i < 3; i++) run_cycle("fl_after");

    // asynchronous reset mid-op
    set_in(0, 0, 0, 0, 0, 0, 1, 20, 0); run_cycle("ar_start");
    idle_in();
    for (int i = 0; i < 4; i++) run_cycle("ar_run");
    #2 rst_n = 1'b0;
    #1;
    chk("ar.stall", 32'(hz.stall_o), 32'd0);
    chk("ar.busy",  32'(hz.busy_o), 32'd0);
    chk("ar.done",  32'(hz.ex_done_o), 32'd0);
    chk("ar.cnt",   hz.stall_cnt_o, 32'd0);
    rem = 0; scnt = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycle("ar_idle");

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 15) == 0), $urandom_range(0, 63),
             ($urandom_range(0, 24) == 0));
      run_cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
